// File: rtl/seq_div_unit.sv
// seq_div_unit: sequential restoring divider, one quotient bit per clock.
// Flow: IDLE -> CHECK -> ITER x WIDTH -> DONE. A zero divisor skips ITER
// and reports div_zero.
// Optional build macro SEQ_DIV_SIGNED_EN adds the sgn port and
// two's-complement handling (truncation toward zero). Latency is the same
// in both builds.
module seq_div_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef SEQ_DIV_SIGNED_EN
  input  logic             sgn,
`endif
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_ITER,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] n_q, d_q;     // operands captured on an accepted start
  logic [WIDTH-1:0] rem_q;        // partial remainder
  logic [WIDTH-1:0] shreg_q;      // dividend bits shifting out, quotient bits in
  logic [CW-1:0]    cnt_q;

  logic             accept;
  logic [WIDTH-1:0] n_mag, d_mag;
  logic [WIDTH:0]   shifted, trial;
  logic             q_bit;
  logic [WIDTH-1:0] rem_nxt, q_raw, q_fin, r_fin;

  // A new request is only looked at when no operation is in flight.
  assign accept = start && (state == S_IDLE || state == S_DONE);

`ifdef SEQ_DIV_SIGNED_EN
  logic sgn_q;
  logic n_neg, d_neg;

  // Operand signs and magnitudes; the core only ever divides magnitudes.
  always_comb begin
    n_neg = sgn_q & n_q[WIDTH-1];
    d_neg = sgn_q & d_q[WIDTH-1];
    n_mag = n_neg ? -n_q : n_q;
    d_mag = d_neg ? -d_q : d_q;
  end

  // Quotient is negative when signs differ; remainder follows the dividend.
  always_comb begin
    q_fin = (n_neg ^ d_neg) ? -q_raw : q_raw;
    r_fin = n_neg ? -rem_nxt : rem_nxt;
  end
`else
  // Unsigned build: operands are already magnitudes.
  always_comb begin
    n_mag = n_q;
    d_mag = d_q;
    q_fin = q_raw;
    r_fin = rem_nxt;
  end
`endif

  // One restoring step: shift in the next dividend bit and trial-subtract.
  // The subtraction is WIDTH+1 bits wide, so its top bit is the borrow.
  // Because rem_q < d_mag, it is set exactly when shifted < d_mag.
  always_comb begin
    shifted = {rem_q, shreg_q[WIDTH-1]};
    trial   = shifted - {1'b0, d_mag};
    q_bit   = ~trial[WIDTH];
    rem_nxt = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    q_raw   = {shreg_q[WIDTH-2:0], q_bit};
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic and status outputs.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_CHECK;
      end
      S_CHECK: begin
        busy      = 1'b1;
        state_nxt = (d_q == '0) ? S_DONE : S_ITER;
      end
      S_ITER: begin
        busy = 1'b1;
        if (cnt_q == '0) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = start ? S_CHECK : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: capture operands, run the iteration, publish results on DONE entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_q       <= '0;
      d_q       <= '0;
      rem_q     <= '0;
      shreg_q   <= '0;
      cnt_q     <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
      sgn_q     <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking so every register here sees pre-edge values.
      if (accept) begin
        n_q      <= dividend;
        d_q      <= divisor;
        div_zero <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
        sgn_q    <= sgn;
`endif
      end
      case (state)
        S_CHECK: begin
          if (d_q == '0) begin
            quotient  <= '1;
            remainder <= n_q;
            div_zero  <= 1'b1;
          end else begin
            rem_q   <= '0;
            shreg_q <= n_mag;
            cnt_q   <= CNT_LAST;
          end
        end
        S_ITER: begin
          rem_q   <= rem_nxt;
          shreg_q <= q_raw;
          if (cnt_q == '0) begin
            quotient  <= q_fin;
            remainder <= r_fin;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
